// File: rtl/alu_multicycle.sv
// EX-stage ALU: single-cycle logic/arith/shift ops plus iterative MULT/MULTU/DIV/DIVU
// that write HI/LO, issued over a valid/ready handshake.
module alu_multicycle #(
   parameter int WIDTH         = 32,
   parameter bit ENABLE_MULDIV = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_con,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             zero,
   output logic             overflow,
   output logic             div_by_zero
);
   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t             r_state;
   logic [SHW-1:0]     r_count;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opA, r_opB;
   logic               r_isDiv, r_negLo, r_negHi, r_dbzPend;
   logic [WIDTH-1:0]   r_result, r_hi, r_lo;
   logic               r_outValid, r_zero, r_overflow, r_divByZero;

   logic               w_accept, w_isMulDiv, w_negA, w_negB, w_scOvf;
   logic [WIDTH-1:0]   w_absA, w_absB, w_sum, w_diff, w_scRes;
   logic [WIDTH:0]     w_mulSum, w_remShift, w_remSub;
   logic [2*WIDTH-1:0] w_mulNext, w_divNext, w_prod;
   logic [WIDTH-1:0]   w_quo, w_rem, w_fixHi, w_fixLo;

   assign w_accept   = in_valid && (r_state == S_IDLE);
   assign w_isMulDiv = ENABLE_MULDIV && (alu_con[3:2] == 2'b11);
   assign w_negA     = ~alu_con[0] & a[WIDTH-1];
   assign w_negB     = ~alu_con[0] & b[WIDTH-1];
   assign w_absA     = w_negA ? -a : a;
   assign w_absB     = w_negB ? -b : b;
   assign w_sum      = a + b;
   assign w_diff     = a - b;

   // Single-cycle datapath; unlisted opcodes (0101, and 11xx without mul/div) behave as ADD.
   always_comb begin
      w_scRes = w_sum;
      w_scOvf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      case (alu_con)
         4'b0110: begin
            w_scRes = w_diff;
            w_scOvf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         4'b0000: begin w_scRes = a & b;    w_scOvf = 1'b0; end
         4'b0001: begin w_scRes = a | b;    w_scOvf = 1'b0; end
         4'b0011: begin w_scRes = ~(a | b); w_scOvf = 1'b0; end
         4'b0100: begin w_scRes = a ^ b;    w_scOvf = 1'b0; end
         4'b0111: begin
            w_scRes = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            w_scOvf = 1'b0;
         end
         4'b1000: begin w_scRes = {{(WIDTH-1){1'b0}}, (a < b)}; w_scOvf = 1'b0; end
         4'b1001: begin w_scRes = a << b[SHW-1:0]; w_scOvf = 1'b0; end
         4'b1010: begin w_scRes = a >> b[SHW-1:0]; w_scOvf = 1'b0; end
         4'b1011: begin w_scRes = $signed(a) >>> b[SHW-1:0]; w_scOvf = 1'b0; end
         default: ;
      endcase
   end

   // r_acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
   assign w_mulSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opB} : '0);
   assign w_mulNext  = {w_mulSum, r_acc[WIDTH-1:1]};
   assign w_remShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_remSub   = w_remShift - {1'b0, r_opB};
   assign w_divNext  = w_remSub[WIDTH] ? {w_remShift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                       : {w_remSub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

   assign w_prod  = r_negLo ? -r_acc : r_acc;
   assign w_quo   = r_negLo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem   = r_negHi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
   assign w_fixHi = !r_isDiv ? w_prod[2*WIDTH-1:WIDTH] : (r_dbzPend ? r_opA : w_rem);
   assign w_fixLo = !r_isDiv ? w_prod[WIDTH-1:0] : (r_dbzPend ? '1 : w_quo);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_acc       <= '0;
         r_opA       <= '0;
         r_opB       <= '0;
         r_isDiv     <= 1'b0;
         r_negLo     <= 1'b0;
         r_negHi     <= 1'b0;
         r_dbzPend   <= 1'b0;
         r_result    <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_outValid  <= 1'b0;
         r_zero      <= 1'b1;
         r_overflow  <= 1'b0;
         r_divByZero <= 1'b0;
      end else begin
         r_outValid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept && w_isMulDiv) begin
                  r_count   <= '0;
                  r_opA     <= a;
                  r_isDiv   <= alu_con[1];
                  r_negLo   <= w_negA ^ w_negB;
                  r_negHi   <= w_negA;
                  r_dbzPend <= 1'b0;
                  if (alu_con[1]) begin
                     r_acc <= {{WIDTH{1'b0}}, w_absA};
                     r_opB <= w_absB;
                     if (b == '0) begin
                        r_dbzPend <= 1'b1;
                        r_state   <= S_FIX;
                     end else begin
                        r_state <= S_DIV;
                     end
                  end else begin
                     r_acc   <= {{WIDTH{1'b0}}, w_absB};
                     r_opB   <= w_absA;
                     r_state <= S_MUL;
                  end
               end else if (w_accept) begin
                  r_result    <= w_scRes;
                  r_zero      <= (w_scRes == '0);
                  r_overflow  <= w_scOvf;
                  r_divByZero <= 1'b0;
                  r_outValid  <= 1'b1;
               end
            end
            S_MUL, S_DIV: begin
               r_acc   <= (r_state == S_MUL) ? w_mulNext : w_divNext;
               r_count <= r_count + SHW'(1);
               if (r_count == SHW'(WIDTH-1)) r_state <= S_FIX;
            end
            S_FIX: begin
               r_hi        <= w_fixHi;
               r_lo        <= w_fixLo;
               r_result    <= w_fixLo;
               r_zero      <= (w_fixLo == '0);
               r_overflow  <= 1'b0;
               r_divByZero <= r_dbzPend;
               r_outValid  <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready    = (r_state == S_IDLE);
   assign out_valid   = r_outValid;
   assign result      = r_result;
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign zero        = r_zero;
   assign overflow    = r_overflow;
   assign div_by_zero = r_divByZero;
endmodule

// File: tb/tb_alu_multicycle.sv
// Randomised and directed bench for alu_multicycle, checked against an arithmetic model
// of the ALU (64-bit products, native signed division) and a few literal vectors.
module tb_alu_multicycle;
   typedef struct {
      logic [31:0] res;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        ovf;
      logic        dbz;
      logic        isMd;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        inValid = 1'b0;
   logic        inValid0 = 1'b0;
   logic [3:0]  aluCon = '0;
   logic [31:0] aIn = '0;
   logic [31:0] bIn = '0;

   logic        inReady, outValid, zero, overflow, divByZero;
   logic [31:0] result, hi, lo;
   logic        inReady0, outValid0, zero0, overflow0, divByZero0;
   logic [31:0] result0, hi0, lo0;

   int          total = 0;
   int          bad = 0;
   int          cycleCount = 0;
   exp_t        expQ[$];
   exp_t        cmpE;
   logic [31:0] mHi = '0;
   logic [31:0] mLo = '0;

   alu_multicycle #(.WIDTH(32), .ENABLE_MULDIV(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
      .alu_con(aluCon), .a(aIn), .b(bIn), .out_valid(outValid), .result(result),
      .hi(hi), .lo(lo), .zero(zero), .overflow(overflow), .div_by_zero(divByZero)
   );

   alu_multicycle #(.WIDTH(32), .ENABLE_MULDIV(1'b0)) dutNoMd (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid0), .in_ready(inReady0),
      .alu_con(aluCon), .a(aIn), .b(bIn), .out_valid(outValid0), .result(result0),
      .hi(hi0), .lo(lo0), .zero(zero0), .overflow(overflow0), .div_by_zero(divByZero0)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   // Reference ALU: plain 64-bit arithmetic; latency counted in clock edges after the accept edge.
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                  input logic [31:0] h, input logic [31:0] l, input logic en);
      exp_t        e;
      longint      sx, sy, s, q, r;
      logic [63:0] up;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      e.hi = h; e.lo = l; e.ovf = 1'b0; e.dbz = 1'b0; e.isMd = 1'b0; e.lat = 0; e.acc = 0;
      e.res = '0;
      if (en && op[3:2] == 2'b11) begin
         e.isMd = 1'b1;
         e.lat  = 33;
         case (op)
            4'b1100: begin s = sx * sy; e.hi = s[63:32]; e.lo = s[31:0]; end
            4'b1101: begin up = {32'b0, x} * {32'b0, y}; e.hi = up[63:32]; e.lo = up[31:0]; end
            default: begin
               if (y == 0) begin
                  e.hi = x; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1; e.lat = 1;
               end else if (op == 4'b1110) begin
                  q = sx / sy; r = sx % sy; e.lo = q[31:0]; e.hi = r[31:0];
               end else begin
                  e.lo = x / y; e.hi = x % y;
               end
            end
         endcase
         e.res = e.lo;
      end else begin
         case (op)
            4'b0110: begin s = sx - sy; e.res = x - y; e.ovf = (s != longint'($signed(e.res))); end
            4'b0000: e.res = x & y;
            4'b0001: e.res = x | y;
            4'b0011: e.res = ~(x | y);
            4'b0100: e.res = x ^ y;
            4'b0111: e.res = (sx < sy) ? 32'd1 : 32'd0;
            4'b1000: e.res = (x < y) ? 32'd1 : 32'd0;
            4'b1001: e.res = x << y[4:0];
            4'b1010: e.res = x >> y[4:0];
            4'b1011: e.res = $signed(x) >>> y[4:0];
            default: begin s = sx + sy; e.res = x + y; e.ovf = (s != longint'($signed(e.res))); end
         endcase
      end
      return e;
   endfunction

   // Compare every result pulse with the oldest outstanding expectation; check busy in_ready.
   always @(negedge clk) begin
      if (rst_n) begin
         if (outValid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected out_valid", {31'b0, outValid}, 32'd0);
            end else begin
               cmpE = expQ.pop_front();
               checkOutput("result", result, cmpE.res);
               checkOutput("hi", hi, cmpE.hi);
               checkOutput("lo", lo, cmpE.lo);
               checkOutput("zero", {31'b0, zero}, {31'b0, (cmpE.res == 0)});
               checkOutput("overflow", {31'b0, overflow}, {31'b0, cmpE.ovf});
               checkOutput("div_by_zero", {31'b0, divByZero}, {31'b0, cmpE.dbz});
               checkOutput("latency", 32'(cycleCount - cmpE.acc), 32'(cmpE.lat));
            end
         end else if (expQ.size() > 0 && expQ[0].isMd && cycleCount >= expQ[0].acc) begin
            checkOutput("in_ready while busy", {31'b0, inReady}, 32'd0);
         end
      end
   end

   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      aluCon = op; aIn = x; bIn = y; inValid = 1'b1;
      while (!inReady && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!inReady) begin
         checkOutput("accept timeout", {31'b0, inReady}, 32'd1);
         inValid = 1'b0;
         return;
      end
      e = model(op, x, y, mHi, mLo, 1'b1);
      e.acc = cycleCount + 1;
      if (e.isMd) begin
         mHi = e.hi;
         mLo = e.lo;
      end
      expQ.push_back(e);
      @(posedge clk);
      #1 inValid = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (expQ.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (expQ.size() > 0) begin
         checkOutput("completion timeout", 32'(expQ.size()), 32'd0);
         expQ.delete();
      end
      #1;
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      exp_t e0;
      repeat (2) @(negedge clk);
      checkOutput("reset in_ready", {31'b0, inReady}, 32'd1);
      checkOutput("reset out_valid", {31'b0, outValid}, 32'd0);
      checkOutput("reset result", result, 32'd0);
      checkOutput("reset hi", hi, 32'd0);
      checkOutput("reset lo", lo, 32'd0);
      checkOutput("reset zero", {31'b0, zero}, 32'd1);
      checkOutput("reset overflow", {31'b0, overflow}, 32'd0);
      checkOutput("reset div_by_zero", {31'b0, divByZero}, 32'd0);
      rst_n = 1'b1;

      applyStimulus(4'b0010, 32'h7FFF_FFFF, 32'h1); waitIdle();
      checkOutput("ADD ovf result", result, 32'h8000_0000);
      checkOutput("ADD ovf flag", {31'b0, overflow}, 32'd1);
      applyStimulus(4'b0111, 32'hFFFF_FFFF, 32'h1); waitIdle();
      checkOutput("SLT neg", result, 32'd1);
      applyStimulus(4'b1000, 32'hFFFF_FFFF, 32'h1); waitIdle();
      checkOutput("SLTU big", result, 32'd0);
      applyStimulus(4'b1011, 32'h8000_0000, 32'd4); waitIdle();
      checkOutput("SRA", result, 32'hF800_0000);
      applyStimulus(4'b1100, 32'hFFFF_FFFD, 32'd5); waitIdle();
      checkOutput("MULT hi", hi, 32'hFFFF_FFFF);
      checkOutput("MULT lo", lo, 32'hFFFF_FFF1);
      applyStimulus(4'b1110, 32'hFFFF_FFF9, 32'd2); waitIdle();
      checkOutput("DIV lo", lo, 32'hFFFF_FFFD);
      checkOutput("DIV hi", hi, 32'hFFFF_FFFF);
      applyStimulus(4'b1111, 32'd7, 32'd0); waitIdle();
      checkOutput("DIVU/0 hi", hi, 32'd7);
      checkOutput("DIVU/0 lo", lo, 32'hFFFF_FFFF);
      checkOutput("DIVU/0 flag", {31'b0, divByZero}, 32'd1);
      applyStimulus(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF); waitIdle();
      checkOutput("DIV min/-1 lo", lo, 32'h8000_0000);
      checkOutput("DIV min/-1 hi", hi, 32'd0);

      applyStimulus(4'b0110, 32'd5, 32'd7);
      applyStimulus(4'b0100, 32'hA5A5_0F0F, 32'hFFFF_0000);
      applyStimulus(4'b0011, 32'h0, 32'h0);
      waitIdle();
      checkOutput("NOR back-to-back", result, 32'hFFFF_FFFF);

      // Reset ten cycles into a MULTU: the op must vanish without a result pulse.
      applyStimulus(4'b1101, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      expQ.delete();
      mHi = '0;
      mLo = '0;
      #1;
      checkOutput("mid-op reset in_ready", {31'b0, inReady}, 32'd1);
      checkOutput("mid-op reset hi", hi, 32'd0);
      checkOutput("mid-op reset lo", lo, 32'd0);
      @(posedge clk);
      #1 checkOutput("mid-op reset out_valid", {31'b0, outValid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(4'b0010, 32'd2, 32'd3); waitIdle();
      checkOutput("ADD after reset", result, 32'd5);

      @(negedge clk);
      aluCon = 4'b1100; aIn = 32'd2; bIn = 32'd3; inValid0 = 1'b1;
      @(posedge clk);
      #1 inValid0 = 1'b0;
      @(negedge clk);
      e0 = model(4'b1100, 32'd2, 32'd3, 32'd0, 32'd0, 1'b0);
      checkOutput("no-muldiv out_valid", {31'b0, outValid0}, 32'd1);
      checkOutput("no-muldiv result", result0, e0.res);
      checkOutput("no-muldiv result literal", result0, 32'd5);
      checkOutput("no-muldiv hi", hi0, 32'd0);
      checkOutput("no-muldiv lo", lo0, 32'd0);

      for (int i = 0; i < 120; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), pickOperand(), pickOperand());
         if ($urandom_range(0, 3) == 0) waitIdle();
      end
      waitIdle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
